// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan sequencer: FSM state encoding and
// the default timeout and gating mask used by the top level.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_GO    = 2'd1,
        ST_ARM   = 2'd2,
        ST_WAIT  = 2'd3
    } scan_state_e;

    // Number of WAIT cycles without a completion strobe before a retry.
    localparam logic [15:0] TIMEOUT_DEFAULT    = 16'hFFF0;

    // Channels 8..15 carry BEMF signals that are only meaningful inside the
    // sensing window, so they are stored only while gate_in is high.
    localparam logic [16:0] GATED_MASK_DEFAULT = 17'h0FF00;

    // Width of the per-visit sample index (settle count is 0..7).
    localparam int          IDX_W              = 3;

endpackage

// File: rtl/adc_result_bank.sv
// Holds the latest stored result for every channel. A write request from
// the sequencer is qualified by the gating mask, and each accepted write
// raises a one-cycle fresh pulse for its channel.
module adc_result_bank
    import adc_pkg::*;
#(
    parameter int                  NUM_CHAN   = 17,
    parameter int                  DATA_W     = 10,
    parameter int                  CHAN_W     = 5,
    parameter logic [NUM_CHAN-1:0] GATED_MASK = NUM_CHAN'(GATED_MASK_DEFAULT)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_req_i,
    input  logic [CHAN_W-1:0]            wr_chan_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         gate_i,
    output logic [NUM_CHAN*DATA_W-1:0]   data_o,
    output logic [NUM_CHAN-1:0]          fresh_o
);

    logic [NUM_CHAN*DATA_W-1:0] data_q, data_d;
    logic [NUM_CHAN-1:0]        fresh_q, fresh_d;
    logic                       store;

    // Decide whether the requested write lands and build the next bank contents.
    always_comb begin
        data_d  = data_q;
        fresh_d = '0;
        store   = wr_req_i && (gate_i || !GATED_MASK[wr_chan_i]);
        if (store) begin
            data_d[wr_chan_i*DATA_W +: DATA_W] = wr_data_i;
            fresh_d[wr_chan_i]                 = 1'b1;
        end
    end

    // Result and fresh-pulse registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            fresh_q <= '0;
        end else begin
            data_q  <= data_d;
            fresh_q <= fresh_d;
        end
    end

    assign data_o  = data_q;
    assign fresh_o = fresh_q;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC scan sequencer. Each enabled channel is converted
// SETTLE+1 times per visit; only the last conversion is stored. A WAIT
// that never sees a completion strobe is abandoned after TIMEOUT cycles
// and the same sample is retried, leaving a sticky error flag behind.
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int                  NUM_CHAN   = 17,
    parameter int                  DATA_W     = 10,
    parameter int                  CHAN_W     = 5,
    parameter int                  SETTLE     = 3,
    parameter logic [15:0]         TIMEOUT    = TIMEOUT_DEFAULT,
    parameter logic [NUM_CHAN-1:0] GATED_MASK = NUM_CHAN'(GATED_MASK_DEFAULT)
) (
    input  logic                         clk3p2M,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            adc_in,
    input  logic                         adc_valid,
    input  logic                         gate_in,
    input  logic [NUM_CHAN-1:0]          chan_en,
    input  logic                         err_clr,
    output logic                         adc_go,
    output logic [CHAN_W-1:0]            adc_chan,
    output logic [NUM_CHAN*DATA_W-1:0]   adc_data,
    output logic [NUM_CHAN-1:0]          data_fresh,
    output logic                         scan_done,
    output logic                         timeout_err
);

    scan_state_e        state_q, state_d;
    logic [CHAN_W-1:0]  cur_q, cur_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               wr_req;
    logic               cur_last;
    logic [CHAN_W-1:0]  cur_inc;

    assign cur_last = (cur_q == CHAN_W'(NUM_CHAN - 1));
    assign cur_inc  = cur_last ? '0 : cur_q + CHAN_W'(1);

    // Next-state logic: channel walk, settle counting, timeout and error flag.
    // A timeout of the WAIT happens on its TIMEOUT-th cycle without a strobe;
    // a strobe in that same cycle is accepted instead.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        wr_req  = 1'b0;
        if (err_clr) begin
            err_d = 1'b0;
        end
        case (state_q)
            ST_SETUP: begin
                if (chan_en[cur_q]) begin
                    state_d = ST_GO;
                end else begin
                    cur_d  = cur_inc;
                    done_d = cur_last;
                end
            end
            ST_GO: begin
                state_d = ST_ARM;
            end
            ST_ARM: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (adc_valid) begin
                    state_d = ST_SETUP;
                    if (idx_q == IDX_W'(SETTLE)) begin
                        wr_req = 1'b1;
                        idx_d  = '0;
                        cur_d  = cur_inc;
                        done_d = cur_last;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (cnt_q == TIMEOUT - 16'd1) begin
                    state_d = ST_SETUP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_SETUP;
            end
        endcase
    end

    // Sequencer state registers with synchronous active-low reset.
    always_ff @(posedge clk3p2M) begin
        if (!rst_n) begin
            state_q <= ST_SETUP;
            cur_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    adc_result_bank #(
        .NUM_CHAN   (NUM_CHAN),
        .DATA_W     (DATA_W),
        .CHAN_W     (CHAN_W),
        .GATED_MASK (GATED_MASK)
    ) u_bank (
        .clk_i     (clk3p2M),
        .rst_ni    (rst_n),
        .wr_req_i  (wr_req),
        .wr_chan_i (cur_q),
        .wr_data_i (adc_in),
        .gate_i    (gate_in),
        .data_o    (adc_data),
        .fresh_o   (data_fresh)
    );

    assign adc_go      = (state_q == ST_GO);
    assign adc_chan    = cur_q;
    assign scan_done   = done_q;
    assign timeout_err = err_q;

endmodule
